// File: rtl/frame_sample_pkg.sv
// Shared types and constants for the frame sample timer.
package frame_sample_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Mid-bit offset for a given divisor: the last count value before mid-bit.
    function automatic int unsigned mid_bit(input int unsigned div);
        return (div >> 32'd1) - 32'd1;
    endfunction

    localparam int unsigned MIN_DIV_DEFAULT  = 32'd4;
    localparam int unsigned BAUD_DIV_DEFAULT = 32'd5208;
    localparam int unsigned MID_BIT_DEFAULT  = mid_bit(BAUD_DIV_DEFAULT); // 2603

endpackage

// File: rtl/frame_sample_timer_div_counter.sv
// Bit-period wrap counter: counts 0 .. limit-1 and flags mid-bit and wrap.
module div_counter #(
    parameter int CNT_W = 15
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             at_half,
    output logic             at_wrap
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] half_s;
    logic [CNT_W-1:0] last_s;

    assign half_s  = (limit >> 1) - CNT_W'(1);
    assign last_s  = limit - CNT_W'(1);
    assign at_half = (count_r == half_s);
    assign at_wrap = (count_r == last_s);
    assign count   = count_r;

    // Advance the bit-period count, wrapping at limit-1; clear holds it at zero.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (at_wrap) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_sample_timer.sv
// Frame sample timer: mid-bit sample strobe, bit index and frame-done for one
// serial RX channel. Optional build macro FRAME_SAMPLE_RESYNC_EN lets a start
// pulse during a frame restart it (realignment after a false start).
module frame_sample_timer
    import frame_sample_pkg::*;
#(
    parameter int CNT_W   = 15,
    parameter int BITS_W  = 4,
    parameter int MIN_DIV = MIN_DIV_DEFAULT
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [CNT_W-1:0]  divisor,
    input  logic [BITS_W-1:0] frame_bits,
    output logic              busy,
    output logic              sample,
    output logic [BITS_W-1:0] bit_idx,
    output logic              frame_done,
    output logic              cfg_err
);

    state_t            state_r, state_nx_s;
    logic [CNT_W-1:0]  div_q_r;
    logic [BITS_W-1:0] nbits_q_r;
    logic [BITS_W-1:0] bit_idx_r, bit_idx_nx_s;
    logic              busy_r, sample_r, frame_done_r, cfg_err_r;
    logic              sample_nx_s, frame_done_nx_s, cfg_err_nx_s;

    logic [CNT_W-1:0]  count_s;
    logic              at_half_s, at_wrap_s, clear_s;
    logic              cfg_ok_s, start_req_s, final_s;
    logic              accept_s, reject_s;

    assign cfg_ok_s    = (divisor >= CNT_W'(MIN_DIV)) && (frame_bits != BITS_W'(0));
    assign start_req_s = enable && start;
    assign final_s     = (state_r == RUN) && at_wrap_s &&
                         (bit_idx_r == (nbits_q_r - BITS_W'(1)));

    // Counter restarts from zero whenever idle, disabled, or a new frame is accepted.
    assign clear_s = !enable || (state_r != RUN) || accept_s;

    div_counter #(.CNT_W(CNT_W)) u_div_counter (
        .sysclk  (sysclk),
        .reset   (reset),
        .clear   (clear_s),
        .limit   (div_q_r),
        .count   (count_s),
        .at_half (at_half_s),
        .at_wrap (at_wrap_s)
    );

    // Decide whether a start pulse is accepted, rejected or ignored this cycle.
    always_comb begin
        accept_s = 1'b0;
        reject_s = 1'b0;
        if (start_req_s) begin
            if ((state_r == IDLE) || final_s) begin
                accept_s = cfg_ok_s;
                reject_s = !cfg_ok_s;
            end else begin
`ifdef FRAME_SAMPLE_RESYNC_EN
                accept_s = cfg_ok_s;
                reject_s = !cfg_ok_s;
`else
                accept_s = 1'b0;
                reject_s = 1'b0;
`endif
            end
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Next state, bit index and strobe values; enable low overrides everything.
    always_comb begin
        state_nx_s      = state_r;
        bit_idx_nx_s    = bit_idx_r;
        sample_nx_s     = 1'b0;
        frame_done_nx_s = 1'b0;
        cfg_err_nx_s    = reject_s;
        if (!enable) begin
            state_nx_s   = IDLE;
            bit_idx_nx_s = BITS_W'(0);
            cfg_err_nx_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bit_idx_nx_s = BITS_W'(0);
                    if (accept_s) begin
                        state_nx_s = RUN;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                RUN: begin
                    if (final_s) begin
                        frame_done_nx_s = 1'b1;
                        bit_idx_nx_s    = BITS_W'(0);
                        state_nx_s      = accept_s ? RUN : IDLE;
                    end else if (accept_s) begin
                        // Realignment: any strobe due on this edge is dropped.
                        bit_idx_nx_s = BITS_W'(0);
                        state_nx_s   = RUN;
                    end else begin
                        sample_nx_s  = at_half_s;
                        bit_idx_nx_s = at_wrap_s ? (bit_idx_r + BITS_W'(1)) : bit_idx_r;
                        state_nx_s   = RUN;
                    end
                end
                default: begin
                    state_nx_s   = IDLE;
                    bit_idx_nx_s = BITS_W'(0);
                end
            endcase
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r      <= IDLE;
            div_q_r      <= '0;
            nbits_q_r    <= '0;
            bit_idx_r    <= '0;
            busy_r       <= 1'b0;
            sample_r     <= 1'b0;
            frame_done_r <= 1'b0;
            cfg_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            bit_idx_r    <= bit_idx_nx_s;
            busy_r       <= (state_nx_s == RUN);
            sample_r     <= sample_nx_s;
            frame_done_r <= frame_done_nx_s;
            cfg_err_r    <= cfg_err_nx_s;
            if (accept_s) begin
                div_q_r   <= divisor;
                nbits_q_r <= frame_bits;
            end else begin
                div_q_r   <= div_q_r;
                nbits_q_r <= nbits_q_r;
            end
        end
    end

    assign busy       = busy_r;
    assign sample     = sample_r;
    assign bit_idx    = bit_idx_r;
    assign frame_done = frame_done_r;
    assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_frame_sample_timer.sv
// Directed self-checking bench for frame_sample_timer (vector table plus
// hand-written long-frame, abort and resync sequences).
module tb_frame_sample_timer;

    localparam int CNT_W  = 15;
    localparam int BITS_W = 4;

    logic              sysclk = 1'b0;
    logic              reset, enable, start;
    logic [CNT_W-1:0]  divisor;
    logic [BITS_W-1:0] frame_bits;
    logic              busy, sample, frame_done, cfg_err;
    logic [BITS_W-1:0] bit_idx;

    int errors = 0;
    int checks = 0;

    always #5 sysclk = ~sysclk;

    frame_sample_timer #(.CNT_W(CNT_W), .BITS_W(BITS_W), .MIN_DIV(4)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .divisor    (divisor),
        .frame_bits (frame_bits),
        .busy       (busy),
        .sample     (sample),
        .bit_idx    (bit_idx),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    typedef struct {
        logic              rst, en, st;
        logic [CNT_W-1:0]  div;
        logic [BITS_W-1:0] fb;
        logic              busy, smp;
        logic [BITS_W-1:0] bidx;
        logic              done, err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic rst, input logic en, input logic st,
                       input int div, input int fb, input logic b, input logic s,
                       input int bi, input logic d, input logic e);
        vec_t v;
        v.rst = rst; v.en = en; v.st = st;
        v.div = CNT_W'(div); v.fb = BITS_W'(fb);
        v.busy = b; v.smp = s; v.bidx = BITS_W'(bi); v.done = d; v.err = e;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int first_s, last_s, nsmp, done_at, bad_gap, busy_pre, bidx_first, bidx_last;
        int found_k, n_done, n_busy, bidx_22, first_after, n_err, err_26;

        reset = 1'b1; enable = 1'b0; start = 1'b0; divisor = '0; frame_bits = '0;

        // ---------------- vector table ----------------
        //   n  rst en st div fb   busy smp bidx done err
        add(2, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0);   // reset
        add(2, 0, 1, 0,  8, 2,   0, 0, 0, 0, 0);   // idle
        add(1, 0, 1, 1,  3, 4,   0, 0, 0, 0, 1);   // divisor below minimum
        add(1, 0, 1, 0,  3, 4,   0, 0, 0, 0, 0);
        add(1, 0, 1, 1,  8, 0,   0, 0, 0, 0, 1);   // zero frame length
        add(1, 0, 1, 0,  8, 0,   0, 0, 0, 0, 0);
        add(1, 0, 0, 1,  3, 4,   0, 0, 0, 0, 0);   // disabled: no error strobe
        // minimum divisor 4, one-bit frame: sample at E0+2, done at E0+4
        add(1, 0, 1, 1,  4, 1,   1, 0, 0, 0, 0);
        add(1, 0, 1, 0,  4, 1,   1, 0, 0, 0, 0);
        add(1, 0, 1, 0,  4, 1,   1, 1, 0, 0, 0);
        add(1, 0, 1, 0,  4, 1,   1, 0, 0, 0, 0);
        add(1, 0, 1, 0,  4, 1,   0, 0, 0, 1, 0);
        add(1, 0, 1, 0,  4, 1,   0, 0, 0, 0, 0);
        // back-to-back, divisor 8, two bits: restart on the done edge
        add(1, 0, 1, 1,  8, 2,   1, 0, 0, 0, 0);   // E0
        add(3, 0, 1, 0,  8, 2,   1, 0, 0, 0, 0);
        add(1, 0, 1, 0,  8, 2,   1, 1, 0, 0, 0);   // E0+4
        add(3, 0, 1, 0,  8, 2,   1, 0, 0, 0, 0);
        add(4, 0, 1, 0,  8, 2,   1, 0, 1, 0, 0);   // E0+8
        add(1, 0, 1, 0,  8, 2,   1, 1, 1, 0, 0);   // E0+12
        add(3, 0, 1, 0,  8, 2,   1, 0, 1, 0, 0);
        add(1, 0, 1, 1,  8, 2,   1, 0, 0, 1, 0);   // E0+16 done + restart
        add(3, 0, 1, 0,  8, 2,   1, 0, 0, 0, 0);
        add(1, 0, 1, 0,  8, 2,   1, 1, 0, 0, 0);   // 4 cycles into frame 2
        add(3, 0, 1, 0,  8, 2,   1, 0, 0, 0, 0);
        add(4, 0, 1, 0,  8, 2,   1, 0, 1, 0, 0);
        add(1, 0, 1, 0,  8, 2,   1, 1, 1, 0, 0);
        add(3, 0, 1, 0,  8, 2,   1, 0, 1, 0, 0);
        add(1, 0, 1, 0,  8, 2,   0, 0, 0, 1, 0);   // frame 2 done
        add(1, 0, 1, 0,  8, 2,   0, 0, 0, 0, 0);
        // configuration changed mid-frame (8->20, 2->1): timing stays 8 x 2
        add(1, 0, 1, 1,  8, 2,   1, 0, 0, 0, 0);
        add(1, 0, 1, 0,  8, 2,   1, 0, 0, 0, 0);
        add(2, 0, 1, 0, 20, 1,   1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 20, 1,   1, 1, 0, 0, 0);
        add(3, 0, 1, 0, 20, 1,   1, 0, 0, 0, 0);
        add(4, 0, 1, 0, 20, 1,   1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 20, 1,   1, 1, 1, 0, 0);
        add(3, 0, 1, 0, 20, 1,   1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 20, 1,   0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 20, 1,   0, 0, 0, 0, 0);
        // reset mid-frame on the edge where a sample was due
        add(1, 0, 1, 1,  8, 2,   1, 0, 0, 0, 0);
        add(3, 0, 1, 0,  8, 2,   1, 0, 0, 0, 0);
        add(1, 1, 1, 0,  8, 2,   0, 0, 0, 0, 0);
        add(2, 0, 1, 0,  8, 2,   0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; enable = vecs[i].en; start = vecs[i].st;
            divisor = vecs[i].div; frame_bits = vecs[i].fb;
            step();
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_sample", i), sample, vecs[i].smp);
            check($sformatf("v%0d_bit_idx", i), bit_idx, vecs[i].bidx);
            check($sformatf("v%0d_frame_done", i), frame_done, vecs[i].done);
            check($sformatf("v%0d_cfg_err", i), cfg_err, vecs[i].err);
        end

        // ---------------- full-rate frame: 5208 x 10 ----------------
        reset = 1'b0; enable = 1'b1; divisor = CNT_W'(5208); frame_bits = BITS_W'(10);
        start = 1'b1;
        step();
        check("long_e0_busy", busy, 1);
        start = 1'b0;
        first_s = -1; last_s = -1; nsmp = 0; done_at = -1; bad_gap = 0;
        busy_pre = 0; bidx_first = -1; bidx_last = -1;
        for (int k = 1; k <= 52085; k++) begin
            step();
            if (sample) begin
                nsmp++;
                if (first_s < 0) begin
                    first_s = k;
                    bidx_first = int'(bit_idx);
                end
                if (last_s >= 0 && (k - last_s) != 5208) bad_gap++;
                last_s = k;
                bidx_last = int'(bit_idx);
            end
            if (frame_done && done_at < 0) done_at = k;
            if (k == 52079) busy_pre = int'(busy);
        end
        check("long_samples", nsmp, 10);
        check("long_first_sample", first_s, 2604);
        check("long_last_sample", last_s, 49476);
        check("long_sample_gap", bad_gap, 0);
        check("long_first_bit_idx", bidx_first, 0);
        check("long_last_bit_idx", bidx_last, 9);
        check("long_done_edge", done_at, 52080);
        check("long_busy_before_end", busy_pre, 1);
        check("long_busy_after", busy, 0);

        // ---------------- abort at bit 2, divisor 16, four bits ----------------
        divisor = CNT_W'(16); frame_bits = BITS_W'(4); start = 1'b1;
        step();
        start = 1'b0;
        found_k = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bit_idx == BITS_W'(2)) begin
                found_k = k;
                break;
            end
        end
        check("abort_reach_bit2", found_k, 32);
        for (int k = 0; k < 7; k++) step();
        enable = 1'b0;   // this edge would otherwise raise sample
        step();
        check("abort_busy", busy, 0);
        check("abort_bit_idx", bit_idx, 0);
        check("abort_sample", sample, 0);
        check("abort_frame_done", frame_done, 0);
        enable = 1'b1;
        n_done = 0; n_busy = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            n_done += int'(frame_done);
            n_busy += int'(busy);
        end
        check("abort_no_done_later", n_done, 0);
        check("abort_stays_idle", n_busy, 0);

        // ---------------- start during a frame: divisor 16, four bits ----------------
        divisor = CNT_W'(16); frame_bits = BITS_W'(4); start = 1'b1;
        step();
        bidx_22 = -1; first_after = -1; done_at = -1; n_err = 0; err_26 = -1; n_done = 0;
        for (int k = 1; k <= 100; k++) begin
            start = (k == 22 || k == 26) ? 1'b1 : 1'b0;
            divisor = (k == 26) ? CNT_W'(3) : CNT_W'(16);
            step();
            if (k == 22) bidx_22 = int'(bit_idx);
            if (k == 26) err_26 = int'(cfg_err);
            if (k > 22 && sample && first_after < 0) first_after = k;
            if (frame_done && done_at < 0) done_at = k;
            n_done += int'(frame_done);
            n_err += int'(cfg_err);
        end
        start = 1'b0;
`ifdef FRAME_SAMPLE_RESYNC_EN
        check("resync_bit_idx", bidx_22, 0);
        check("resync_next_sample", first_after, 30);
        check("resync_done_edge", done_at, 86);
        check("resync_bad_cfg_err", err_26, 1);
        check("resync_err_count", n_err, 1);
`else
        check("resync_bit_idx", bidx_22, 1);
        check("resync_next_sample", first_after, 24);
        check("resync_done_edge", done_at, 64);
        check("resync_bad_cfg_err", err_26, 0);
        check("resync_err_count", n_err, 0);
`endif
        check("resync_done_count", n_done, 1);
        check("resync_final_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
